// File: rtl/uart_hex_sender_if.sv
// Handshake bundle between the monitor sequencer, the hex line sender and the UART TX byte queue.
interface uart_hex_sender_if;
    logic        snd_start;
    logic [63:0] snd_data;
    logic        short_mode;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        flushing_wq;
    logic        busy;
    logic        ovr_err;

    modport master (
        output snd_start, snd_data, short_mode, tx_ready,
        input  tx_data, tx_valid, flushing_wq, busy, ovr_err
    );

    modport slave (
        input  snd_start, snd_data, short_mode, tx_ready,
        output tx_data, tx_valid, flushing_wq, busy, ovr_err
    );
endinterface

// File: rtl/uart_hex_sender.sv
// Formats a dump/PC word pair as an ASCII hex line and streams it to the UART TX queue.
// Define HEX_LOWERCASE_EN to emit 'a'-'f' instead of 'A'-'F'.
module uart_hex_sender #(
    parameter int         NL_CRLF  = 1,
    parameter logic [7:0] SEP_CHAR = 8'h20
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_hex_sender_if.slave    bus
);

`ifdef HEX_LOWERCASE_EN
    localparam logic [7:0] HEX_ALPHA = 8'h61;
`else
    localparam logic [7:0] HEX_ALPHA = 8'h41;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEXL,
        S_SEP,
        S_HEXH,
        S_CR,
        S_LF
    } state_t;

    localparam state_t S_EOL = (NL_CRLF != 0) ? S_CR : S_LF;

    state_t      r_state;
    state_t      w_next;
    logic [63:0] r_data;
    logic        r_short;
    logic [2:0]  r_cnt;
    logic        r_flush;
    logic        r_ovr;

    logic        w_valid;
    logic        w_xfer;
    logic [31:0] w_word;
    logic [31:0] w_shifted;
    logic [3:0]  w_nib;
    logic [7:0]  w_hex;
    logic [7:0]  w_byte;

    assign w_valid = (r_state != S_IDLE);
    assign w_xfer  = w_valid & bus.tx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (bus.snd_start) w_next = S_HEXL;
            S_HEXL: if (w_xfer && r_cnt == 3'd7) w_next = r_short ? S_EOL : S_SEP;
            S_SEP:  if (w_xfer) w_next = S_HEXH;
            S_HEXH: if (w_xfer && r_cnt == 3'd7) w_next = S_EOL;
            S_CR:   if (w_xfer) w_next = S_LF;
            S_LF:   if (w_xfer) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Counter wraps 7->0 on the same transfer that leaves a hex state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_short <= 1'b0;
            r_cnt   <= '0;
            r_flush <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_flush <= (r_state == S_LF) && w_xfer;
            r_ovr   <= bus.snd_start && (r_state != S_IDLE);
            if (r_state == S_IDLE && bus.snd_start) begin
                r_data  <= bus.snd_data;
                r_short <= bus.short_mode;
                r_cnt   <= '0;
            end else if ((r_state == S_HEXL || r_state == S_HEXH) && w_xfer) begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    // Most-significant nibble first: shift the selected word left by 4*count.
    assign w_word    = (r_state == S_HEXH) ? r_data[63:32] : r_data[31:0];
    assign w_shifted = w_word << {r_cnt, 2'b00};
    assign w_nib     = w_shifted[31:28];
    assign w_hex     = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib})
                                       : (HEX_ALPHA + {4'h0, w_nib} - 8'd10);

    always_comb begin
        w_byte = '0;
        unique case (r_state)
            S_HEXL, S_HEXH: w_byte = w_hex;
            S_SEP:          w_byte = SEP_CHAR;
            S_CR:           w_byte = 8'h0D;
            S_LF:           w_byte = 8'h0A;
            default:        w_byte = '0;
        endcase
    end

    assign bus.tx_data     = w_byte;
    assign bus.tx_valid    = w_valid;
    assign bus.busy        = w_valid;
    assign bus.flushing_wq = r_flush;
    assign bus.ovr_err     = r_ovr;

endmodule

// File: tb/tb_uart_hex_sender.sv
// Bench for uart_hex_sender: two instances (CRLF and LF-only) checked against a byte-queue line model.
module tb_uart_hex_sender;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] data;
    logic        short;
    logic        fix_rdy;
    logic        rnd_rdy;
    logic        rnd_bit;
    logic        rdy;
    int          cyc;

    int nchk;
    int nerr;

    uart_hex_sender_if ifa();
    uart_hex_sender_if ifb();

    assign rdy = rnd_rdy ? rnd_bit : fix_rdy;

    assign ifa.snd_start  = start;
    assign ifa.snd_data   = data;
    assign ifa.short_mode = short;
    assign ifa.tx_ready   = rdy;
    assign ifb.snd_start  = start;
    assign ifb.snd_data   = data;
    assign ifb.short_mode = short;
    assign ifb.tx_ready   = rdy;

    uart_hex_sender u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    uart_hex_sender #(.NL_CRLF(0)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    logic [7:0] o_data  [2];
    logic       o_valid [2];
    logic       o_flush [2];
    logic       o_busy  [2];
    logic       o_ovr   [2];

    assign o_data[0]  = ifa.tx_data;
    assign o_valid[0] = ifa.tx_valid;
    assign o_flush[0] = ifa.flushing_wq;
    assign o_busy[0]  = ifa.busy;
    assign o_ovr[0]   = ifa.ovr_err;
    assign o_data[1]  = ifb.tx_data;
    assign o_valid[1] = ifb.tx_valid;
    assign o_flush[1] = ifb.flushing_wq;
    assign o_busy[1]  = ifb.busy;
    assign o_ovr[1]   = ifb.ovr_err;

    // Model state per instance
    logic [7:0] mq   [2][$];
    logic [7:0] cap  [2][$];
    bit         m_crlf [2];
    bit         m_busy [2];
    bit         m_flush[2];
    bit         m_ovr  [2];
    int         first_cyc[2];
    int         flush_cyc[2];
    int         ovr_cyc  [2];
    int         t_start;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    task automatic chk(string name, int d, logic [63:0] act, logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s dut%0d cyc=%0d: got %0h expected %0h", name, d, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] hexc(int n);
        if (n < 10) return 8'(48 + n);
`ifdef HEX_LOWERCASE_EN
        return 8'(97 + n - 10);
`else
        return 8'(65 + n - 10);
`endif
    endfunction

    function automatic void push_line(int d, logic [63:0] v, bit sm);
        logic [31:0] w;
        for (int h = 0; h < (sm ? 1 : 2); h++) begin
            w = (h == 0) ? v[31:0] : v[63:32];
            if (h == 1) mq[d].push_back(8'h20);
            for (int i = 7; i >= 0; i--) mq[d].push_back(hexc(int'((w >> (4 * i)) & 32'hF)));
        end
        if (m_crlf[d]) mq[d].push_back(8'h0D);
        mq[d].push_back(8'h0A);
    endfunction

    // Compare process: every cycle, outputs vs. model, then advance the model.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                mq[d].delete();
                m_busy[d]  = 0;
                m_flush[d] = 0;
                m_ovr[d]   = 0;
                chk("rst_valid", d, 64'(o_valid[d]), 64'd0);
                chk("rst_data",  d, 64'(o_data[d]),  64'd0);
                chk("rst_flush", d, 64'(o_flush[d]), 64'd0);
                chk("rst_busy",  d, 64'(o_busy[d]),  64'd0);
                chk("rst_ovr",   d, 64'(o_ovr[d]),   64'd0);
            end else begin
                bit nbusy, nflush, novr;
                chk("busy",     d, 64'(o_busy[d]),  64'(m_busy[d]));
                chk("tx_valid", d, 64'(o_valid[d]), 64'(m_busy[d]));
                chk("flush",    d, 64'(o_flush[d]), 64'(m_flush[d]));
                chk("ovr_err",  d, 64'(o_ovr[d]),   64'(m_ovr[d]));
                nbusy  = m_busy[d];
                nflush = 0;
                novr   = 0;
                if (o_flush[d]) flush_cyc[d] = cyc;
                if (o_ovr[d]) ovr_cyc[d] = cyc;
                if (m_busy[d] && o_valid[d]) begin
                    if (mq[d].size() == 0) begin
                        chk("model_underrun", d, 64'd1, 64'd0);
                    end else begin
                        chk("tx_data", d, 64'(o_data[d]), 64'(mq[d][0]));
                        if (rdy) begin
                            if (cap[d].size() == 0) first_cyc[d] = cyc;
                            cap[d].push_back(o_data[d]);
                            void'(mq[d].pop_front());
                            if (mq[d].size() == 0) begin
                                nbusy  = 0;
                                nflush = 1;
                            end
                        end
                    end
                end
                if (start) begin
                    if (m_busy[d]) novr = 1;
                    else begin
                        push_line(d, data, short);
                        nbusy = 1;
                    end
                end
                m_busy[d]  = nbusy;
                m_flush[d] = nflush;
                m_ovr[d]   = novr;
            end
        end
    end

    task automatic send(logic [63:0] dv, bit sm, bit now);
        if (!now) begin
            @(posedge clk);
            #1;
        end
        start   = 1'b1;
        data    = dv;
        short   = sm;
        t_start = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(bit noise);
        int n = 0;
        while ((m_busy[0] || m_busy[1]) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            if (noise && $urandom_range(0, 15) == 0) begin
                start = 1'b1;
                data  = {$urandom, $urandom};
                short = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("idle_timeout", 0, 64'(n < 3000), 64'd1);
    endtask

    task automatic settle();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_caps();
        for (int d = 0; d < 2; d++) begin
            cap[d].delete();
            first_cyc[d] = -1;
            flush_cyc[d] = -1;
            ovr_cyc[d]   = -1;
        end
    endtask

    task automatic check_lit(int d, string body, bit crlf);
        int n;
        n = body.len() + (crlf ? 2 : 1);
        chk("line_len", d, 64'(cap[d].size()), 64'(n));
        if (cap[d].size() == n) begin
            for (int i = 0; i < body.len(); i++) chk("line_byte", d, 64'(cap[d][i]), 64'(body[i]));
            if (crlf) chk("line_cr", d, 64'(cap[d][n-2]), 64'h0D);
            chk("line_lf", d, 64'(cap[d][n-1]), 64'h0A);
        end
    endtask

    initial begin
        nchk = 0;
        nerr = 0;
        m_crlf[0] = 1;
        m_crlf[1] = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        data    = '0;
        short   = 1'b0;
        fix_rdy = 1'b1;
        rnd_rdy = 1'b0;
        clear_caps();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        settle();

        // Full line, always ready
        clear_caps();
        send(64'h89ABCDEF_01234567, 1'b0, 1'b0);
        wait_idle(1'b0);
        settle();
        check_lit(0, "01234567 89ABCDEF", 1'b1);
        check_lit(1, "01234567 89ABCDEF", 1'b0);
        chk("first_byte_lat", 0, 64'(first_cyc[0] - t_start), 64'd1);
        chk("flush_cycle",    0, 64'(flush_cyc[0] - t_start), 64'd20);
        chk("flush_cycle",    1, 64'(flush_cyc[1] - t_start), 64'd19);

        // Short mode
        clear_caps();
        send(64'hFFFF_FFFF_0000_0040, 1'b1, 1'b0);
        wait_idle(1'b0);
        settle();
        check_lit(0, "00000040", 1'b1);
        check_lit(1, "00000040", 1'b0);
        chk("short_flush", 0, 64'(flush_cyc[0] - t_start), 64'd11);

        // Mixed hex digits, LF-only instance
        clear_caps();
        send(64'h0000_00FF_DEAD_BEEF, 1'b0, 1'b0);
        wait_idle(1'b0);
        settle();
`ifdef HEX_LOWERCASE_EN
        check_lit(1, "deadbeef 000000ff", 1'b0);
`else
        check_lit(1, "DEADBEEF 000000FF", 1'b0);
`endif

        // Random backpressure: same bytes as the first line
        clear_caps();
        rnd_rdy = 1'b1;
        send(64'h89ABCDEF_01234567, 1'b0, 1'b0);
        wait_idle(1'b0);
        rnd_rdy = 1'b0;
        settle();
        check_lit(0, "01234567 89ABCDEF", 1'b1);

        // Overlapping request at cycle 5 is dropped
        clear_caps();
        send(64'h89ABCDEF_01234567, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        data  = 64'h1111_2222_3333_4444;
        short = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle(1'b0);
        repeat (30) @(posedge clk);
        #1;
        chk("ovr_cycle", 0, 64'(ovr_cyc[0] - t_start), 64'd6);
        chk("ovr_cycle", 1, 64'(ovr_cyc[1] - t_start), 64'd6);
        check_lit(0, "01234567 89ABCDEF", 1'b1);

        // Reset during HEXH, then a clean line
        clear_caps();
        send(64'h89ABCDEF_01234567, 1'b0, 1'b0);
        repeat (11) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("midrst_valid", d, 64'(o_valid[d]), 64'd0);
            chk("midrst_data",  d, 64'(o_data[d]),  64'd0);
            chk("midrst_busy",  d, 64'(o_busy[d]),  64'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        settle();
        chk("no_flush_after_rst", 0, 64'(flush_cyc[0]), 64'hFFFF_FFFF_FFFF_FFFF);
        clear_caps();
        send(64'h89ABCDEF_01234567, 1'b0, 1'b0);
        wait_idle(1'b0);
        settle();
        check_lit(0, "01234567 89ABCDEF", 1'b1);

        // Randomized lines with noise requests and back-to-back starts
        for (int k = 0; k < 40; k++) begin
            rnd_rdy = 1'($urandom_range(0, 1));
            send({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_idle(1'b1);
        end
        rnd_rdy = 1'b0;
        settle();
        for (int d = 0; d < 2; d++) chk("model_drained", d, 64'(mq[d].size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
